// File: rtl/spad_dma_engine.sv
// spad_dma_engine: CSR-programmed block mover between system Avalon-MM memory
// and a private single-port word scratchpad, one word in flight at a time.
module spad_dma_engine #(
  parameter int SPAD_AW = 12,
  parameter int MEM_AW = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         s_address,
  input  logic               s_chipselect,
  input  logic               s_read,
  input  logic               s_write,
  input  logic [31:0]        s_writedata,
  output logic [31:0]        s_readdata,
  output logic               irq,
  output logic [MEM_AW-1:0]  m_address,
  output logic               m_read,
  output logic               m_write,
  output logic [3:0]         m_byteenable,
  output logic [31:0]        m_writedata,
  input  logic               m_waitrequest,
  input  logic [31:0]        m_readdata,
  input  logic               m_readdatavalid,
  output logic [SPAD_AW-1:0] spad_address,
  output logic               spad_chipselect,
  output logic               spad_write,
  output logic [3:0]         spad_byteenable,
  output logic [31:0]        spad_writedata,
  input  logic [31:0]        spad_readdata
);
  localparam logic [2:0] IDLE = 3'd0, MRD = 3'd1, MRDV = 3'd2, SWR = 3'd3,
                         SRD = 3'd4, SCAP = 3'd5, MWR = 3'd6, FIN = 3'd7;
  localparam int LW = SPAD_AW + 1;
  localparam logic [LW-1:0] MAX_LEN = {1'b1, {SPAD_AW{1'b0}}};
  logic [2:0] state;
  logic [MEM_AW-1:0] src, cur_addr;
  logic [SPAD_AW-1:0] idx, cur_idx;
  logic [LW-1:0] len, remaining;
  logic [31:0] data, csr_val;
  logic dir, irq_en, done, busy, wr, rd, go, step, last, finish;
  assign busy = state != IDLE;
  assign wr = s_chipselect & s_write;
  assign rd = s_chipselect & s_read;
  assign go = wr && s_address == 3'd3 && s_writedata[0] && !busy;
  assign step = state == SWR || (state == MWR && !m_waitrequest);
  assign last = remaining == LW'(1);
  // FIN is the one-cycle busy window of a zero-length transfer
  assign finish = state == FIN || (step && last);
  assign irq = done & irq_en;
  assign m_read = state == MRD;
  assign m_write = state == MWR;
  assign m_address = cur_addr;
  assign m_byteenable = (m_read | m_write) ? 4'hF : 4'h0;
  assign m_writedata = data;
  assign spad_address = cur_idx;
  assign spad_chipselect = state == SWR || state == SRD;
  assign spad_write = state == SWR;
  assign spad_byteenable = 4'hF;
  assign spad_writedata = data;
  assign csr_val = s_address == 3'd0 ? 32'(src) :
                   s_address == 3'd1 ? 32'(idx) :
                   s_address == 3'd2 ? 32'(len) :
                   s_address == 3'd3 ? {29'd0, irq_en, dir, 1'b0} :
                   s_address == 3'd4 ? {30'd0, done, busy} : 32'd0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      src <= '0;
      idx <= '0;
      len <= '0;
      cur_addr <= '0;
      cur_idx <= '0;
      remaining <= '0;
      data <= '0;
      dir <= 1'b0;
      irq_en <= 1'b0;
      done <= 1'b0;
      s_readdata <= '0;
    end else begin
      s_readdata <= rd ? csr_val : 32'd0;
      if (wr && !busy) begin
        if (s_address == 3'd0) src <= {s_writedata[MEM_AW-1:2], 2'b00};
        if (s_address == 3'd1) idx <= s_writedata[SPAD_AW-1:0];
        if (s_address == 3'd2) len <= s_writedata > 32'(MAX_LEN) ? MAX_LEN : s_writedata[LW-1:0];
        if (s_address == 3'd3) {irq_en, dir} <= s_writedata[2:1];
      end
      if (go) begin
        cur_addr <= src;
        cur_idx <= idx;
        remaining <= len;
        state <= len == '0 ? FIN : s_writedata[1] ? SRD : MRD;
      end
      case (state)
        MRD:  if (!m_waitrequest) state <= MRDV;
        MRDV: if (m_readdatavalid) begin
          data <= m_readdata;
          state <= SWR;
        end
        SRD:  state <= SCAP;
        SCAP: begin
          data <= spad_readdata;
          state <= MWR;
        end
        FIN:  state <= IDLE;
        default: ;
      endcase
      if (step) begin
        cur_addr <= cur_addr + MEM_AW'(4);
        cur_idx <= cur_idx + SPAD_AW'(1);
        remaining <= remaining - LW'(1);
        state <= last ? IDLE : dir ? SRD : MRD;
      end
      // completion is applied after the clear so a coincident clear loses
      if (wr && s_address == 3'd4 && s_writedata[1]) done <= 1'b0;
      if (finish) done <= 1'b1;
    end
endmodule

// File: tb/tb_spad_dma_engine.sv
// tb_spad_dma_engine: directed bench with behavioural memory/scratchpad models
// and scoreboards of expected bus transactions.
`timescale 1ns/1ps
module tb_spad_dma_engine;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [2:0] s_address = 3'd0;
  logic s_chipselect = 1'b0, s_read = 1'b0, s_write = 1'b0;
  logic [31:0] s_writedata = 32'd0, s_readdata;
  logic irq, m_read, m_write, spad_chipselect, spad_write;
  logic [31:0] m_address, m_writedata, spad_writedata;
  logic [3:0] m_byteenable, spad_byteenable;
  logic m_waitrequest = 1'b0, m_readdatavalid = 1'b0;
  logic [31:0] m_readdata = 32'd0, spad_readdata = 32'd0;
  logic [11:0] spad_address;
  int vectors = 0, errs = 0, nrd = 0, nmw = 0, nsw = 0, rstall = 0, wstall = 0, wcnt = 0;
  logic stray = 1'b0, hold = 1'b0, rdv_pend = 1'b0;
  logic [31:0] rdv_data = 32'd0, haddr = 32'd0, hdata = 32'd0, sq = 32'd0;
  logic [31:0] smem [4096];
  logic [31:0] exp_raddr[$], rdata_q[$];
  logic [43:0] exp_sw[$];
  logic [63:0] exp_mw[$];

  always #5 clk = ~clk;

  spad_dma_engine dut (
    .clk(clk), .reset_n(reset_n),
    .s_address(s_address), .s_chipselect(s_chipselect), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .irq(irq),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .spad_address(spad_address), .spad_chipselect(spad_chipselect),
    .spad_write(spad_write), .spad_byteenable(spad_byteenable),
    .spad_writedata(spad_writedata), .spad_readdata(spad_readdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    s_chipselect = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
    tick(1);
    s_chipselect = 1'b0; s_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    s_chipselect = 1'b1; s_read = 1'b1; s_address = a;
    tick(1);
    d = s_readdata;
    s_chipselect = 1'b0; s_read = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] d = 32'd0;
    for (int i = 0; i < 200 && !d[1]; i++) csr_rd(3'd4, d);
    check(tag, 64'(d[1:0]), 64'h2);
    csr_wr(3'd4, 32'h2);
  endtask

  // memory and scratchpad models, evaluated 1ns after each rising edge
  always @(posedge clk) begin
    #1;
    m_readdatavalid = rdv_pend;
    m_readdata = rdv_data;
    rdv_pend = 1'b0;
    if (stray && spad_chipselect && spad_write) begin
      m_readdatavalid = 1'b1;
      m_readdata = 32'hDEADBEEF;
      stray = 1'b0;
    end
    spad_readdata = sq;
    sq = smem[spad_address];
    if (spad_chipselect && spad_write) begin
      smem[spad_address] = spad_writedata;
      nsw++;
      if (exp_sw.size() > 0) check("spad_wr", 64'({spad_address, spad_writedata}), 64'(exp_sw.pop_front()));
    end
    if (m_read || m_write) begin
      if (hold) begin
        check("stall_addr", 64'(m_address), 64'(haddr));
        if (m_write) check("stall_data", 64'(m_writedata), 64'(hdata));
      end
      m_waitrequest = wcnt < (m_read ? rstall : wstall);
      if (m_waitrequest) begin
        wcnt++; hold = 1'b1; haddr = m_address; hdata = m_writedata;
      end else begin
        wcnt = 0; hold = 1'b0;
        check("m_be", 64'(m_byteenable), 64'hF);
        if (m_read) begin
          nrd++;
          if (exp_raddr.size() > 0) check("m_raddr", 64'(m_address), 64'(exp_raddr.pop_front()));
          rdv_pend = 1'b1;
          rdv_data = rdata_q.size() > 0 ? rdata_q.pop_front() : m_address ^ 32'h5A5A0000;
        end else begin
          nmw++;
          check("m_wr", {m_address, m_writedata}, exp_mw.size() > 0 ? exp_mw.pop_front() : 64'hx);
        end
      end
    end else begin
      m_waitrequest = 1'b0; wcnt = 0; hold = 1'b0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int n0, n1;
    tick(2);
    reset_n = 1'b1;
    // reset while stalled in a memory read
    rstall = 1000;
    csr_wr(3'd0, 32'h5000); csr_wr(3'd2, 32'd2); csr_wr(3'd3, 32'h1);
    tick(2);
    check("mrd_before_rst", 64'(m_read), 64'h1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_m_read", 64'(m_read), 64'h0);
    check("rst_m_write", 64'(m_write), 64'h0);
    check("rst_m_be", 64'(m_byteenable), 64'h0);
    check("rst_m_addr", 64'(m_address), 64'h0);
    check("rst_spad_cs", 64'({spad_chipselect, spad_write}), 64'h0);
    check("rst_spad_be", 64'(spad_byteenable), 64'hF);
    check("rst_irq", 64'(irq), 64'h0);
    tick(1);
    reset_n = 1'b1; rstall = 0;
    csr_rd(3'd4, d); check("rst_status", 64'(d), 64'h0);
    csr_rd(3'd2, d); check("rst_len", 64'(d), 64'h0);
    // mem->spad, zero wait, irq timing
    for (int i = 0; i < 4; i++) begin
      exp_raddr.push_back(32'h1000 + 32'(4 * i));
      rdata_q.push_back(32'hA0 + 32'(i));
      exp_sw.push_back({12'h010 + 12'(i), 32'hA0 + 32'(i)});
    end
    csr_wr(3'd0, 32'h1003);
    csr_rd(3'd0, d); check("src_align", 64'(d), 64'h1000);
    csr_wr(3'd1, 32'h10); csr_wr(3'd2, 32'd4);
    n0 = nsw;
    csr_wr(3'd3, 32'h5);
    tick(11); check("irq_11", 64'(irq), 64'h0);
    tick(1);  check("irq_12", 64'(irq), 64'h1);
    csr_rd(3'd4, d); check("t1_status", 64'(d), 64'h2);
    check("t1_words", 64'(nsw - n0), 64'd4);
    check("t1_sb", 64'(exp_sw.size() + exp_raddr.size()), 64'd0);
    csr_wr(3'd4, 32'h2); check("irq_clr", 64'(irq), 64'h0);
    // preload wrap-around scratchpad words, then spad->mem with stalls
    rdata_q.push_back(32'h11); rdata_q.push_back(32'h22); rdata_q.push_back(32'h33);
    exp_sw.push_back({12'hFFE, 32'h11}); exp_sw.push_back({12'hFFF, 32'h22}); exp_sw.push_back({12'h000, 32'h33});
    csr_wr(3'd0, 32'h3000); csr_wr(3'd1, 32'hFFE); csr_wr(3'd2, 32'd3); csr_wr(3'd3, 32'h1);
    wait_done("t2a_done");
    wstall = 2;
    exp_mw.push_back({32'h2000, 32'h11}); exp_mw.push_back({32'h2004, 32'h22}); exp_mw.push_back({32'h2008, 32'h33});
    n0 = nmw;
    csr_wr(3'd0, 32'h2000); csr_wr(3'd1, 32'hFFE); csr_wr(3'd2, 32'd3); csr_wr(3'd3, 32'h3);
    wait_done("t2b_done");
    check("t2b_writes", 64'(nmw - n0), 64'd3);
    check("t2b_sb", 64'(exp_mw.size()), 64'd0);
    wstall = 0;
    // zero length
    n0 = nrd;
    csr_wr(3'd2, 32'd0); csr_wr(3'd3, 32'h1);
    csr_rd(3'd4, d); check("len0_busy", 64'(d), 64'h1);
    csr_rd(3'd4, d); check("len0_done", 64'(d), 64'h2);
    check("len0_no_read", 64'(nrd - n0), 64'd0);
    check("len0_irq", 64'(irq), 64'h0);
    csr_wr(3'd4, 32'h2);
    // busy guard plus stray readdatavalid
    for (int i = 0; i < 8; i++) begin
      exp_raddr.push_back(32'h4000 + 32'(4 * i));
      exp_sw.push_back({12'h100 + 12'(i), (32'h4000 + 32'(4 * i)) ^ 32'h5A5A0000});
    end
    csr_wr(3'd0, 32'h4000); csr_wr(3'd1, 32'h100); csr_wr(3'd2, 32'd8);
    n0 = nsw;
    csr_wr(3'd3, 32'h1);
    csr_wr(3'd0, 32'hDEAD0000); csr_wr(3'd2, 32'd2);
    stray = 1'b1;
    wait_done("t4_done");
    check("t4_words", 64'(nsw - n0), 64'd8);
    check("t4_sb", 64'(exp_sw.size() + exp_raddr.size()), 64'd0);
    csr_rd(3'd0, d); check("t4_src_kept", 64'(d), 64'h4000);
    csr_rd(3'd2, d); check("t4_len_kept", 64'(d), 64'd8);
    // completion coinciding with DONE clear
    exp_sw.push_back({12'h200, 32'h6000 ^ 32'h5A5A0000});
    csr_wr(3'd0, 32'h6000); csr_wr(3'd1, 32'h200); csr_wr(3'd2, 32'd1);
    n0 = nsw;
    csr_wr(3'd3, 32'h1);
    tick(2);
    csr_wr(3'd4, 32'h2);
    csr_rd(3'd4, d); check("set_wins", 64'(d), 64'h2);
    check("t5_words", 64'(nsw - n0), 64'd1);
    csr_wr(3'd4, 32'h2);
    // full depth with clamped length
    csr_wr(3'd2, 32'd5000);
    csr_rd(3'd2, d); check("len_clamp", 64'(d), 64'd4096);
    csr_wr(3'd0, 32'h8000); csr_wr(3'd1, 32'h0);
    n0 = nsw; n1 = nrd;
    csr_wr(3'd3, 32'h5);
    for (int i = 0; i < 13000 && !irq; i++) tick(1);
    check("full_irq", 64'(irq), 64'h1);
    tick(5);
    csr_rd(3'd4, d); check("full_status", 64'(d), 64'h2);
    check("full_spad_writes", 64'(nsw - n0), 64'd4096);
    check("full_mem_reads", 64'(nrd - n1), 64'd4096);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
